multicycle_control: RTL

Multi-cycle control unit for the CPU core, superseding the single-cycle combinational opcode decoder. It sequences each instruction through fetch, decode, execute, memory and write-back states and waits on a memory ready handshake. Compared with the single-cycle decoder it adds LDR, BEQ and HALT, illegal-opcode detection, and a retired-instruction counter. It sits between the instruction register / PC logic and the datapath (register file, ALU, data memory).

---
 rtl/multicycle_control.sv | 110 +++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// multicycle_control: FSM sequencing fetch/decode/execute/memory/write-back with a memory
// ready handshake, illegal-opcode detection and a retired-instruction counter.
module multicycle_control #(
  parameter int OPCODE_W = 3,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                ir_write,
  output logic                pc_write,
  output logic                ldpc,
  output logic                mem_read,
  output logic                mem_write,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic [1:0]          alu_op,
  output logic                alu_src,
  output logic                branch,
  output logic                illegal,
  output logic                halted,
  output logic [2:0]          state,
  output logic [CNT_W-1:0]    retired
);
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
    S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6
  } state_t;
  localparam logic [2:0] OP_SUB = 3'd1, OP_LDI = 3'd2, OP_XOR = 3'd3,
                         OP_STR = 3'd4, OP_LDR = 3'd5, OP_BEQ = 3'd6, OP_HALT = 3'd7;
  state_t state_q, state_d;
  logic [2:0] op_q;
  logic [CNT_W-1:0] retired_q;
  logic retire, bad_op;
  logic [2:0] alu_ctl;
  assign bad_op  = |(opcode >> 3);
  assign alu_ctl = (op_q == OP_SUB || op_q == OP_BEQ) ? 3'b110 :
                   (op_q == OP_XOR)                   ? 3'b010 :
                   (op_q == OP_LDI)                   ? 3'b101 :
                   (op_q == OP_STR || op_q == OP_LDR) ? 3'b001 : 3'b000;
  assign state   = state_q;
  assign retired = retired_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= opcode[2:0];
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end
  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    ldpc       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_op     = 2'b00;
    alu_src    = 1'b0;
    branch     = 1'b0;
    illegal    = 1'b0;
    halted     = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_read = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
        state_d  = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        illegal = bad_op;
        state_d = bad_op ? S_FETCH : (opcode[2:0] == OP_HALT) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        {alu_op, alu_src} = alu_ctl;
        branch  = op_q == OP_BEQ;
        ldpc    = (op_q == OP_BEQ) & zero;
        retire  = op_q == OP_BEQ;
        state_d = (op_q == OP_BEQ) ? S_FETCH :
                  (op_q == OP_STR || op_q == OP_LDR) ? S_MEM : S_WB;
      end
      S_MEM: begin
        alu_src   = 1'b1;
        mem_write = op_q == OP_STR;
        mem_read  = op_q == OP_LDR;
        retire    = mem_ready & (op_q == OP_STR);
        state_d   = !mem_ready ? S_MEM : (op_q == OP_STR) ? S_FETCH : S_WB;
      end
      S_WB: begin
        // Loads write memory data; everything else keeps the ALU result stable through write-back.
        reg_write  = 1'b1;
        mem_to_reg = op_q == OP_LDR;
        {alu_op, alu_src} = (op_q == OP_LDR) ? 3'b000 : alu_ctl;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end
endmodule
